pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. Every cycle it decides whether each pipeline register (PC, IF/ID, ID/EX) advances, holds, or is flushed to NOP, and when the PC is redirected. Requests come from EX (taken jump/branch), ID (load-use hazard), the bus (memory wait) and an external interrupt line. It resolves them by fixed priority and sequences the multi-cycle cases with a small state machine.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// default interrupt vector, pipeline NOP and the per-cycle control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h0000_0100;

    // addi x0, x0, 0 -- what IF/ID and ID/EX load when flushed
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic id_ex_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_load;
        logic irq_ack;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-cycle hold/flush/redirect decisions for PC, IF/ID, ID/EX.
// Latency: zero, all outputs are combinational from state plus current inputs.
// Backpressure: mem_wait_i freezes the whole pipe; a jump seen while frozen is kept pending.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 255,
    parameter logic [31:0] IRQ_VEC       = IRQ_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        load_use_i,
    input  logic        mem_wait_i,
    input  logic        irq_i,
    input  logic        irq_en_i,
    output logic        pc_hold_o,
    output logic        if_id_hold_o,
    output logic        id_ex_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        pc_load_o,
    output logic [31:0] pc_load_addr_o,
    output logic        irq_ack_o,
    output logic        timeout_o
);

    localparam logic [2:0]  FLUSH_INIT    = 3'(FLUSH_CYCLES);
    localparam logic [15:0] STALL_LIMIT   = 16'(STALL_TIMEOUT);
    localparam logic [1:0]  REDIRECT_NEXT = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;

    logic [1:0]  state_q,     state_d;
    logic        pend_jump_q, pend_jump_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q,   timeout_d;

    ctrl_t       ctrl;
    logic [31:0] load_addr;
    logic        run_eval;
    logic        redirect;
    logic [31:0] redir_addr;

    always_comb begin
        state_d     = state_q;
        pend_jump_d = pend_jump_q;
        pend_addr_d = pend_addr_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        ctrl        = CTRL_IDLE;
        load_addr   = '0;
        run_eval    = 1'b0;
        redirect    = 1'b0;
        redir_addr  = '0;

        case (state_q)
            ST_RUN: run_eval = 1'b1;

            ST_WAIT: begin
                if (mem_wait_i) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.if_id_hold = 1'b1;
                    ctrl.id_ex_hold = 1'b1;
                    stall_cnt_d     = sat_inc16(stall_cnt_q);
                    if (sat_inc16(stall_cnt_q) == STALL_LIMIT) begin
                        timeout_d = 1'b1;
                    end
                    if (jump_en_i) begin
                        pend_jump_d = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else begin
                    stall_cnt_d = '0;
                    state_d     = ST_RUN;
                    if (pend_jump_q) begin
                        redirect    = 1'b1;
                        redir_addr  = pend_addr_q;
                        pend_jump_d = 1'b0;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                ctrl.if_id_flush = 1'b1;
                if (mem_wait_i) begin
                    // counter frozen; a jump arriving now is replayed once the bus frees
                    ctrl.pc_hold    = 1'b1;
                    ctrl.if_id_hold = 1'b1;
                    ctrl.id_ex_hold = 1'b1;
                    if (jump_en_i) begin
                        pend_jump_d = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (jump_en_i || pend_jump_q) begin
                    redirect    = 1'b1;
                    redir_addr  = jump_en_i ? jump_addr_i : pend_addr_q;
                    pend_jump_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: state_d = ST_RUN;
        endcase

        if (run_eval) begin
            if (mem_wait_i) begin
                ctrl.pc_hold    = 1'b1;
                ctrl.if_id_hold = 1'b1;
                ctrl.id_ex_hold = 1'b1;
                state_d         = ST_WAIT;
                if (jump_en_i) begin
                    pend_jump_d = 1'b1;
                    pend_addr_d = jump_addr_i;
                end
            end else if (jump_en_i) begin
                redirect   = 1'b1;
                redir_addr = jump_addr_i;
            end else if (irq_i && irq_en_i) begin
                redirect     = 1'b1;
                redir_addr   = IRQ_VEC;
                ctrl.irq_ack = 1'b1;
            end else if (load_use_i) begin
                ctrl.pc_hold     = 1'b1;
                ctrl.if_id_hold  = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
        end

        if (redirect) begin
            ctrl.pc_load     = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            load_addr        = redir_addr;
            flush_cnt_d      = FLUSH_INIT;
            state_d          = REDIRECT_NEXT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_jump_q <= 1'b0;
            pend_addr_q <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_jump_q <= pend_jump_d;
            pend_addr_q <= pend_addr_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // outputs forced quiet for the whole reset assertion, not just after the edge
    assign pc_hold_o      = ctrl.pc_hold     & ~rst;
    assign if_id_hold_o   = ctrl.if_id_hold  & ~rst;
    assign id_ex_hold_o   = ctrl.id_ex_hold  & ~rst;
    assign if_id_flush_o  = ctrl.if_id_flush & ~rst;
    assign id_ex_flush_o  = ctrl.id_ex_flush & ~rst;
    assign pc_load_o      = ctrl.pc_load     & ~rst;
    assign irq_ack_o      = ctrl.irq_ack     & ~rst;
    assign timeout_o      = timeout_d        & ~rst;
    assign pc_load_addr_o = rst ? 32'h0 : load_addr;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle's inputs are driven and the Mealy
// outputs compared at the falling edge against hand-computed flag words.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic        mem_wait_i;
    logic        irq_i;
    logic        irq_en_i;
    logic        pc_hold_o;
    logic        if_id_hold_o;
    logic        id_ex_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        pc_load_o;
    logic [31:0] pc_load_addr_o;
    logic        irq_ack_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    // flag word: {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, pc_load, irq_ack, timeout}
    localparam logic [7:0] F_NONE  = 8'h00;
    localparam logic [7:0] F_TO    = 8'h01;
    localparam logic [7:0] F_HOLD  = 8'hE0;
    localparam logic [7:0] F_LU    = 8'hC8;
    localparam logic [7:0] F_REDIR = 8'h1C;
    localparam logic [7:0] F_IRQ   = 8'h1E;
    localparam logic [7:0] F_IFF   = 8'h10;

    pipe_ctrl #(
        .FLUSH_CYCLES (1),
        .STALL_TIMEOUT(3),
        .IRQ_VEC      (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .load_use_i    (load_use_i),
        .mem_wait_i    (mem_wait_i),
        .irq_i         (irq_i),
        .irq_en_i      (irq_en_i),
        .pc_hold_o     (pc_hold_o),
        .if_id_hold_o  (if_id_hold_o),
        .id_ex_hold_o  (id_ex_hold_o),
        .if_id_flush_o (if_id_flush_o),
        .id_ex_flush_o (id_ex_flush_o),
        .pc_load_o     (pc_load_o),
        .pc_load_addr_o(pc_load_addr_o),
        .irq_ack_o     (irq_ack_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic j, input logic [31:0] ja, input logic lu,
                         input logic mw, input logic irq, input logic ie);
        jump_en_i   = j;
        jump_addr_i = ja;
        load_use_i  = lu;
        mem_wait_i  = mw;
        irq_i       = irq;
        irq_en_i    = ie;
    endtask

    task automatic expect_cyc(input string tag, input logic [7:0] f, input logic [31:0] a);
        logic [7:0] got;
        @(negedge clk);
        got = {pc_hold_o, if_id_hold_o, id_ex_hold_o, if_id_flush_o,
               id_ex_flush_o, pc_load_o, irq_ack_o, timeout_o};
        check({tag, " flags"}, {24'h0, got}, {24'h0, f});
        check({tag, " addr"}, pc_load_addr_o, a);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        expect_cyc(tag, F_NONE, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_cyc("reset_gated", F_NONE, 32'h0);
        rst = 1'b0;

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("idle", F_NONE, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0); expect_cyc("load_use", F_LU, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("load_use_after", F_NONE, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); expect_cyc("irq_disabled", F_NONE, 32'h0);

        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("jump_c0", F_REDIR, 32'h40);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);  expect_cyc("jump_c1_lu_ignored", F_IFF, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("jump_c2", F_NONE, 32'h0);

        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1); expect_cyc("irq_vs_jump", F_REDIR, 32'h40);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);  expect_cyc("irq_in_flush", F_IFF, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);  expect_cyc("irq_taken", F_IRQ, 32'h100);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("irq_flush", F_IFF, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("irq_done", F_NONE, 32'h0);

        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("to_run", F_HOLD, 32'h0);
        expect_cyc("to_w1", F_HOLD, 32'h0);
        expect_cyc("to_w2", F_HOLD, 32'h0);
        expect_cyc("to_w3", F_HOLD | F_TO, 32'h0);
        expect_cyc("to_w4", F_HOLD | F_TO, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cyc("to_exit", F_TO, 32'h0);
        expect_cyc("to_sticky", F_TO, 32'h0);
        do_reset("to_reset");
        expect_cyc("to_cleared", F_NONE, 32'h0);

        drive(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0); expect_cyc("jw_c0", F_HOLD, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);  expect_cyc("jw_c1", F_HOLD, 32'h0);
        expect_cyc("jw_c2", F_HOLD, 32'h0);
        expect_cyc("jw_c3", F_HOLD | F_TO, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("jw_release", F_REDIR | F_TO, 32'h80);
        expect_cyc("jw_flush", F_IFF | F_TO, 32'h0);
        expect_cyc("jw_done", F_TO, 32'h0);
        do_reset("jw_reset");

        drive(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0); expect_cyc("lw_c0", F_HOLD, 32'h0);
        drive(1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b0); expect_cyc("lw_c1", F_HOLD, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("lw_release", F_REDIR, 32'hA0);
        expect_cyc("lw_flush", F_IFF, 32'h0);
        expect_cyc("lw_done", F_NONE, 32'h0);

        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("fz_jump", F_REDIR, 32'h40);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);  expect_cyc("fz_wait", F_HOLD | F_IFF, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("fz_frozen_cnt", F_IFF, 32'h0);
        expect_cyc("fz_done", F_NONE, 32'h0);

        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("rj_jump", F_REDIR, 32'h40);
        drive(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("rj_reissue", F_REDIR, 32'h50);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("rj_flush", F_IFF, 32'h0);
        expect_cyc("rj_done", F_NONE, 32'h0);

        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0); expect_cyc("rm_jump", F_REDIR, 32'h40);
        drive(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b0); expect_cyc("rm_pend", F_HOLD | F_IFF, 32'h0);
        do_reset("rm_reset");
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("rm_idle", F_NONE, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);  expect_cyc("rm_wait", F_HOLD, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);  expect_cyc("rm_no_stale_pend", F_NONE, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
